// File: rtl/seg_frame_driver_if.sv
// Load handshake and display-side signals shared between a frame writer/rotator
// and the segment frame driver.
interface seg_frame_driver_if;
  logic [7:0]  anode_in;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  anode_out;
  logic [6:0]  cathode;
  logic        dp_out;
  logic        frame_done;

  modport master (
    output anode_in, data_in, dp_in, load_valid,
    input  load_ready, anode_out, cathode, dp_out, frame_done
  );

  modport slave (
    input  anode_in, data_in, dp_in, load_valid,
    output load_ready, anode_out, cathode, dp_out, frame_done
  );
endinterface

// File: rtl/seg_frame_driver.sv
// Double-buffered 8-digit hex frame driver: decodes the rotator's anode select into
// registered cathode/dp/anode outputs, committing new frames only at 7F->FE boundaries.
module seg_frame_driver #(
  parameter bit LZ_BLANK = 1'b1
) (
  input logic          clock,
  input logic          reset,
  seg_frame_driver_if.slave bus
);

  logic [31:0] active_data, shadow_data, frame_data;
  logic [7:0]  active_dp, shadow_dp, frame_dp, prev_anode;
  logic [7:1]  upper_zero;
  logic        shadow_full, boundary, commit, load_fire, digit_valid, blank;
  logic [2:0]  digit_idx;
  logic [3:0]  nibble;
  logic [6:0]  seg_pattern;

  assign bus.load_ready = !shadow_full;
  assign load_fire      = bus.load_valid && !shadow_full;
  assign boundary       = (prev_anode == 8'h7F) && (bus.anode_in == 8'hFE);
  assign commit         = boundary && shadow_full;

  // Digit 0 registered on the boundary edge must already show the committed frame.
  assign frame_data = commit ? shadow_data : active_data;
  assign frame_dp   = commit ? shadow_dp   : active_dp;

  always_comb begin
    digit_valid = 1'b1;
    digit_idx   = 3'd0;
    case (bus.anode_in)
      8'hFE:   digit_idx = 3'd0;
      8'hFD:   digit_idx = 3'd1;
      8'hFB:   digit_idx = 3'd2;
      8'hF7:   digit_idx = 3'd3;
      8'hEF:   digit_idx = 3'd4;
      8'hDF:   digit_idx = 3'd5;
      8'hBF:   digit_idx = 3'd6;
      8'h7F:   digit_idx = 3'd7;
      default: digit_valid = 1'b0;
    endcase
  end

  always_comb begin
    upper_zero = '0;
    for (int i = 1; i < 8; i++)
      upper_zero[i] = ((frame_data >> (4 * i)) == 32'h0);
  end

  assign nibble = frame_data[{digit_idx, 2'b00} +: 4];
  assign blank  = LZ_BLANK && (digit_idx != 3'd0) && upper_zero[digit_idx];

  always_comb begin
    seg_pattern = 7'h7F;
    case (nibble)
      4'h0: seg_pattern = 7'h40;
      4'h1: seg_pattern = 7'h79;
      4'h2: seg_pattern = 7'h24;
      4'h3: seg_pattern = 7'h30;
      4'h4: seg_pattern = 7'h19;
      4'h5: seg_pattern = 7'h12;
      4'h6: seg_pattern = 7'h02;
      4'h7: seg_pattern = 7'h78;
      4'h8: seg_pattern = 7'h00;
      4'h9: seg_pattern = 7'h10;
      4'hA: seg_pattern = 7'h08;
      4'hB: seg_pattern = 7'h03;
      4'hC: seg_pattern = 7'h46;
      4'hD: seg_pattern = 7'h21;
      4'hE: seg_pattern = 7'h06;
      4'hF: seg_pattern = 7'h0E;
      default: seg_pattern = 7'h7F;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_data    <= '0;
      active_dp      <= '0;
      shadow_data    <= '0;
      shadow_dp      <= '0;
      shadow_full    <= 1'b0;
      prev_anode     <= 8'hFF;
      bus.anode_out  <= 8'hFF;
      bus.cathode    <= 7'h7F;
      bus.dp_out     <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      prev_anode     <= bus.anode_in;
      bus.frame_done <= boundary;
      // Commit needs a full shadow and a load needs an empty one, so they never collide.
      if (commit) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
        shadow_full <= 1'b0;
      end else if (load_fire) begin
        shadow_data <= bus.data_in;
        shadow_dp   <= bus.dp_in;
        shadow_full <= 1'b1;
      end
      if (digit_valid) begin
        bus.anode_out <= bus.anode_in;
        bus.cathode   <= blank ? 7'h7F : seg_pattern;
        bus.dp_out    <= ~frame_dp[digit_idx];
      end else begin
        bus.anode_out <= 8'hFF;
        bus.cathode   <= 7'h7F;
        bus.dp_out    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_frame_driver.md
# seg_frame_driver

Segment-side companion to the 8-digit anode rotator. The rotator emits a rotating active-low one-hot anode select; this block consumes that select, holds a double-buffered 32-bit display frame (eight hex nibbles plus eight decimal points), and drives the matching cathode pattern, decimal point and a re-timed anode. New frames are loaded through a valid/ready handshake and committed only at frame boundaries, so the display never tears mid-scan.

## Interface
- LZ_BLANK, 1, 1 = blank leading zero digits 7..1; 0 = show all digits
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- anode_in  in  8  active-low one-hot digit select from rotator (8'hFE = digit 0 … 8'h7F = digit 7)
- data_in  in  32  frame to load; nibble i (bits 4i+3:4i) shown on digit i
- dp_in  in  8  decimal points to load; bit i = 1 lights dp of digit i
- load_valid  in  1  writer offers data_in/dp_in
- load_ready  out  1  shadow buffer empty; transfer occurs when load_valid && load_ready
- anode_out  out  8  anode_in delayed one cycle, forced 8'hFF when anode_in invalid
- cathode  out  7  active-low segments, bit6..0 = g,f,e,d,c,b,a
- dp_out  out  1  active-low decimal point
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: active frame (32+8 bits), shadow frame (32+8 bits), shadow_full, prev_anode (8).
- load_ready = !shadow_full (combinational). Handshake: load_valid && load_ready captures data_in/dp_in into shadow, sets shadow_full. load_valid may drop any time without effect.
- Frame boundary: prev_anode == 8'h7F && anode_in == 8'hFE. At boundary: frame_done <= 1; if shadow_full, active <= shadow and shadow_full <= 0. Otherwise active keeps its value (last frame repeats).
- Load and boundary in same cycle with shadow empty: data goes into shadow only; committed at the next boundary, not this one.
- prev_anode <= anode_in every cycle.
- Digit decode: anode_in one of FE,FD,FB,F7,EF,DF,BF,7F → index 0..7. Any other pattern (incl. FF, multiple lows) invalid → cathode 7'h7F, dp_out 1, anode_out 8'hFF.
- Hex to cathode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Leading-zero blanking (LZ_BLANK=1): digit i (i ≥ 1) blanked (cathode 7'h7F) when nibbles i..7 of active are all zero. Digit 0 never blanked. dp is independent of blanking: dp_out = ~active_dp[i].
- Anode is not blanked by LZ; only cathode goes dark.

## Timing
- cathode, dp_out, anode_out registered: reflect anode_in sampled at edge N, valid after edge N (1-cycle latency), so anode_out and cathode stay aligned.
- A committed frame is used from the first digit-0 output after the boundary edge (same edge that registers digit 0 uses the new active value).
- frame_done asserted for exactly one cycle, the cycle after the boundary edge.
- Reset (synchronous, dominates all): active data 0, active dp 0, shadow 0, shadow_full 0, prev_anode 8'hFF, anode_out 8'hFF, cathode 7'h7F, dp_out 1, frame_done 0; load_ready reads 1 in the cycle following reset.
- Reset mid-load or mid-frame discards shadow and active; first boundary after reset requires a full 7F→FE transition.
- Rotator holding anode (no rotate pulse) → outputs static, no boundary, no commit.

## Test plan
- Reset then scan with no load: all digits with LZ_BLANK=1 → digit 0 cathode 7'h40, digits 1–7 cathode 7'h7F, dp_out 1.
- Load 32'h89ABCDEF, dp 8'h01 mid-frame → load_ready drops next cycle; current frame unchanged; after 7F→FE boundary digit 0 shows 7'h0E with dp_out 0, digit 7 shows 7'h00; load_ready returns to 1, frame_done pulses once.
- Second load while shadow_full with load_valid held → no capture until boundary; captured the cycle after load_ready rises; committed one frame later.
- Load 32'h00000120 with LZ_BLANK=1 → digits 3–7 blank, digit 2 = 7'h79, digit 1 = 7'h24, digit 0 = 7'h40; with LZ_BLANK=0 digits 3–7 = 7'h40.
- Drive anode_in 8'hFC and 8'hFF → one cycle later anode_out 8'hFF, cathode 7'h7F, dp_out 1; no commit or frame_done.
- Assert reset with shadow_full and active nonzero mid-scan → next cycle all outputs at reset values, load_ready 1, old shadow never displayed.
